fpmult_zero_bypass_ctrl: RTL and testbench

- Control stage directly upstream of the zero-operand detector in the single/double-precision FP multiplier datapath.
- Captures the two operands and pulses the detector's register load.
- Reads back the registered zero flag, then either short-circuits to a signed-zero result or launches the significand multiplier and waits for it.
- Holds the final IEEE result under a ready/ack handshake toward the FPU interface.

---
 rtl/fpmult_pkg.sv | 20 ++
 rtl/fpmult_zero_bypass_ctrl_if.sv | 31 +++
 rtl/fpmult_timeout_cnt.sv | 29 ++
 rtl/fpmult_zero_bypass_ctrl.sv | 143 ++++++++++++++
 tb/tb_fpmult_zero_bypass_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpmult_pkg.sv
// Shared types and helpers for the FP multiplier zero-bypass control slice.
package fpmult_pkg;

  localparam int W_SP = 32;
  localparam int W_DP = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_DONE
  } state_t;

  // Returns a W_DP-wide word with only bit w-1 set to the sign; callers truncate to w bits.
  function automatic logic [W_DP-1:0] signed_zero(input logic sign, input int w);
    return {{(W_DP-1){1'b0}}, sign} << (w - 1);
  endfunction

endpackage

// File: rtl/fpmult_zero_bypass_ctrl_if.sv
// Operand, detector, multiplier and result handshake bundle around the zero-bypass controller.
interface fpmult_zero_bypass_ctrl_if #(
  parameter int W = 32
);
  logic         beg_fsm;
  logic         ack_fsm;
  logic [W-1:0] Data_MX;
  logic [W-1:0] Data_MY;
  logic         zero_m_flag;
  logic         mult_done;
  logic [W-1:0] mult_result;
  logic         load_zero;
  logic [W-2:0] Op_A;
  logic [W-2:0] Op_B;
  logic         start_mult;
  logic [W-1:0] final_result;
  logic         ready;
  logic         zero_flag;
  logic         timeout_flag;

  modport master (
    input  beg_fsm, ack_fsm, Data_MX, Data_MY, zero_m_flag, mult_done, mult_result,
    output load_zero, Op_A, Op_B, start_mult, final_result, ready, zero_flag, timeout_flag
  );

  modport slave (
    output beg_fsm, ack_fsm, Data_MX, Data_MY, zero_m_flag, mult_done, mult_result,
    input  load_zero, Op_A, Op_B, start_mult, final_result, ready, zero_flag, timeout_flag
  );

endinterface

// File: rtl/fpmult_timeout_cnt.sv
// Loadable up-counter measuring cycles elapsed since the multiplier launch.
module fpmult_timeout_cnt #(
  parameter int TO_CYC = 63,
  localparam int CW = $clog2(TO_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] count;

  // Load seeds 1 because the launch cycle itself is the first elapsed cycle;
  // tc flags the cycle whose closing edge brings the count to TO_CYC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc = en && (count == CW'(TO_CYC - 1));

endmodule

// File: rtl/fpmult_zero_bypass_ctrl.sv
// Zero-bypass control stage: captures operands, consults the zero detector, then either
// returns a signed zero or runs the significand multiplier under a timeout.
//
// state    | meaning
// ST_IDLE  | waiting for beg_fsm, operands captured on start
// ST_LOAD  | load_zero strobe, detector registers its flag
// ST_CHECK | read zero flag: bypass to DONE or launch multiplier
// ST_RUN   | waiting for mult_done or timeout
// ST_DONE  | result held with ready until ack_fsm
module fpmult_zero_bypass_ctrl
  import fpmult_pkg::*;
#(
  parameter int W      = W_SP,
  parameter int TO_CYC = 63
) (
  input logic                      clk,
  input logic                      rst,
  fpmult_zero_bypass_ctrl_if.master bus
);

  state_t       state_q;
  state_t       state_d;
  logic [W-2:0] op_x_q;
  logic [W-2:0] op_y_q;
  logic         sign_q;
  logic [W-1:0] result_q;
  logic         zero_q;
  logic         timeout_q;
  logic [W-1:0] zero_res;
  logic         cnt_load;
  logic         cnt_en;
  logic         cnt_tc;

  assign zero_res = W'(signed_zero(sign_q, W));

  fpmult_timeout_cnt #(
    .TO_CYC(TO_CYC)
  ) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.load_zero  = 1'b0;
    bus.start_mult = 1'b0;
    bus.ready      = 1'b0;
    cnt_load       = 1'b0;
    cnt_en         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.beg_fsm) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        bus.load_zero = 1'b1;
        state_d       = ST_CHECK;
      end
      ST_CHECK: begin
        if (bus.zero_m_flag) begin
          state_d = ST_DONE;
        end else begin
          bus.start_mult = 1'b1;
          cnt_load       = 1'b1;
          state_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (bus.mult_done || cnt_tc) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.ready = 1'b1;
        if (bus.ack_fsm) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_x_q    <= '0;
      op_y_q    <= '0;
      sign_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.beg_fsm) begin
            op_x_q <= bus.Data_MX[W-2:0];
            op_y_q <= bus.Data_MY[W-2:0];
            sign_q <= bus.Data_MX[W-1] ^ bus.Data_MY[W-1];
          end
        end
        ST_CHECK: begin
          if (bus.zero_m_flag) begin
            result_q  <= zero_res;
            zero_q    <= 1'b1;
            timeout_q <= 1'b0;
          end
        end
        ST_RUN: begin
          // A completion on the terminal-count cycle still counts as a normal finish.
          if (bus.mult_done) begin
            result_q  <= bus.mult_result;
            zero_q    <= 1'b0;
            timeout_q <= 1'b0;
          end else if (cnt_tc) begin
            result_q  <= zero_res;
            zero_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.ack_fsm) begin
            zero_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Op_A         = op_x_q;
  assign bus.Op_B         = op_y_q;
  assign bus.final_result = result_q;
  assign bus.zero_flag    = zero_q;
  assign bus.timeout_flag = timeout_q;

endmodule

// File: tb/tb_fpmult_zero_bypass_ctrl.sv
// Directed scoreboard bench for the zero-bypass controller, single and double precision.
module tb_fpmult_zero_bypass_ctrl;
  import fpmult_pkg::*;

  localparam int TO_CYC = 63;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        tmo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          use64 = 1'b0;
  logic        beg = 1'b0;
  logic        ack = 1'b0;
  logic        mdone = 1'b0;
  logic [63:0] x = '0;
  logic [63:0] y = '0;
  logic [63:0] mres = '0;
  logic        zf32, zf64;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  fpmult_zero_bypass_ctrl_if #(.W(32)) bus32 ();
  fpmult_zero_bypass_ctrl_if #(.W(64)) bus64 ();

  fpmult_zero_bypass_ctrl #(.W(32), .TO_CYC(TO_CYC)) dut32 (.clk(clk), .rst(rst), .bus(bus32.master));
  fpmult_zero_bypass_ctrl #(.W(64), .TO_CYC(TO_CYC)) dut64 (.clk(clk), .rst(rst), .bus(bus64.master));

  assign bus32.beg_fsm     = use64 ? 1'b0 : beg;
  assign bus32.ack_fsm     = use64 ? 1'b0 : ack;
  assign bus32.mult_done   = use64 ? 1'b0 : mdone;
  assign bus32.Data_MX     = x[31:0];
  assign bus32.Data_MY     = y[31:0];
  assign bus32.mult_result = mres[31:0];
  assign bus64.beg_fsm     = use64 ? beg : 1'b0;
  assign bus64.ack_fsm     = use64 ? ack : 1'b0;
  assign bus64.mult_done   = use64 ? mdone : 1'b0;
  assign bus64.Data_MX     = x;
  assign bus64.Data_MY     = y;
  assign bus64.mult_result = mres;

  // Zero-detect unit model: registers "either magnitude is zero" on load_zero.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      zf32 <= 1'b0;
      zf64 <= 1'b0;
    end else begin
      if (bus32.load_zero) zf32 <= (bus32.Op_A == '0) || (bus32.Op_B == '0);
      if (bus64.load_zero) zf64 <= (bus64.Op_A == '0) || (bus64.Op_B == '0);
    end
  end
  assign bus32.zero_m_flag = zf32;
  assign bus64.zero_m_flag = zf64;

  function automatic logic [63:0] o_result();
    return use64 ? bus64.final_result : {32'b0, bus32.final_result};
  endfunction
  function automatic logic [63:0] o_opa();
    return use64 ? {1'b0, bus64.Op_A} : {33'b0, bus32.Op_A};
  endfunction
  function automatic logic o_ready();
    return use64 ? bus64.ready : bus32.ready;
  endfunction
  function automatic logic o_zero();
    return use64 ? bus64.zero_flag : bus32.zero_flag;
  endfunction
  function automatic logic o_tmo();
    return use64 ? bus64.timeout_flag : bus32.timeout_flag;
  endfunction
  function automatic logic o_load();
    return use64 ? bus64.load_zero : bus32.load_zero;
  endfunction
  function automatic logic o_start();
    return use64 ? bus64.start_mult : bus32.start_mult;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // n: cycles from start_mult to mult_done; n<1 means the multiplier never answers.
  task automatic do_op(input string tag, input logic [63:0] xa, input logic [63:0] ya, input int n,
                       input logic [63:0] mr, input int hold, input bit ack_early);
    int          w;
    logic [63:0] mask, sz;
    exp_t        e, got;
    int          cyc, s_cyc, starts, loads;
    w    = use64 ? 64 : 32;
    mask = use64 ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
    sz   = '0;
    sz[w-1] = xa[w-1] ^ ya[w-1];
    if (((xa & mask) == '0) || ((ya & mask) == '0)) begin
      e.res = sz; e.zero = 1'b1; e.tmo = 1'b0; e.lat = 3;
    end else if (n >= 1 && n <= TO_CYC - 1) begin
      e.res = mr; e.zero = 1'b0; e.tmo = 1'b0; e.lat = 3 + n;
    end else begin
      e.res = sz; e.zero = 1'b0; e.tmo = 1'b1; e.lat = TO_CYC + 2;
    end
    sb.push_back(e);

    x = xa; y = ya; beg = 1'b1; ack = ack_early; mres = mr;
    tick();
    beg = 1'b0;
    cyc = 1; s_cyc = -1; starts = 0; loads = 0;
    while (cyc < 200 && !o_ready()) begin
      if (o_load()) loads++;
      if (o_start()) begin
        starts++;
        s_cyc = cyc;
      end
      mdone = (s_cyc >= 0) && (n >= 1) && (cyc == s_cyc + n);
      tick();
      cyc++;
    end
    mdone = 1'b0;

    got = sb.pop_front();
    check({tag, "_ready_seen"}, o_ready(), 1);
    check({tag, "_latency"}, cyc, got.lat);
    check({tag, "_result"}, o_result(), got.res);
    check({tag, "_zero_flag"}, o_zero(), got.zero);
    check({tag, "_timeout_flag"}, o_tmo(), got.tmo);
    check({tag, "_load_pulses"}, loads, 1);
    check({tag, "_start_pulses"}, starts, got.zero ? 0 : 1);
    check({tag, "_op_a"}, o_opa(), xa & mask);

    if (ack_early) begin
      tick();
      ack = 1'b0;
      check({tag, "_early_ack_ready"}, o_ready(), 0);
      return;
    end

    for (int i = 0; i < hold; i++) begin
      beg = i[0];
      x   = ~xa;
      tick();
    end
    beg = 1'b0;
    x   = xa;
    if (hold > 0) begin
      check({tag, "_hold_ready"}, o_ready(), 1);
      check({tag, "_hold_result"}, o_result(), got.res);
      check({tag, "_hold_op_a"}, o_opa(), xa & mask);
    end

    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_ack_ready"}, o_ready(), 0);
    check({tag, "_ack_zero"}, o_zero(), 0);
    check({tag, "_ack_tmo"}, o_tmo(), 0);
    check({tag, "_ack_keep"}, o_result(), got.res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst32_ready", bus32.ready, 0);
    check("rst32_load", bus32.load_zero, 0);
    check("rst32_start", bus32.start_mult, 0);
    check("rst32_result", bus32.final_result, 0);
    check("rst64_result", bus64.final_result, 0);
    check("rst64_ready", bus64.ready, 0);
    rst = 1'b0;
    tick();

    use64 = 1'b0;
    do_op("zero_pos", 64'h0000_0000, 64'h3F80_0000, 0, 64'h0, 0, 1'b0);
    do_op("zero_neg", 64'h8000_0000, 64'h4000_0000, 0, 64'h0, 0, 1'b0);
    do_op("norm_n5", 64'h3F80_0000, 64'h4000_0000, 5, 64'h4000_0000, 0, 1'b0);
    do_op("timeout", 64'h3F80_0000, 64'hC000_0000, -1, 64'h1234_5678, 0, 1'b0);
    do_op("tc_tie", 64'h4040_0000, 64'h4000_0000, TO_CYC - 1, 64'h40C0_0000, 0, 1'b0);
    do_op("norm_n1", 64'h4040_0000, 64'h3F80_0000, 1, 64'h4040_0000, 10, 1'b0);
    do_op("early_ack", 64'hBF80_0000, 64'h0000_0000, 0, 64'h0, 0, 1'b1);

    mdone = 1'b1;
    mres  = 64'hDEAD_BEEF;
    tick();
    tick();
    mdone = 1'b0;
    check("idle_mdone_ready", bus32.ready, 0);
    check("idle_mdone_result", bus32.final_result, 64'h8000_0000);

    x = 64'h3F80_0000; y = 64'h4000_0000; beg = 1'b1;
    tick();
    beg = 1'b0;
    repeat (6) tick();
    #3 rst = 1'b1;
    #1;
    check("arst_ready", bus32.ready, 0);
    check("arst_result", bus32.final_result, 0);
    check("arst_op_a", bus32.Op_A, 0);
    check("arst_start", bus32.start_mult, 0);
    check("arst_load", bus32.load_zero, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    check("post_rst_ready", bus32.ready, 0);

    use64 = 1'b1;
    do_op("dp_zero", 64'h0, 64'h4000_0000_0000_0000, 0, 64'h0, 0, 1'b0);
    do_op("dp_norm", 64'h3FF0_0000_0000_0000, 64'hC000_0000_0000_0000, 3, 64'hC000_0000_0000_0000, 0, 1'b0);
    do_op("dp_zneg", 64'h8000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 0, 64'h0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
